// File: rtl/ornek1_pkg.sv
// Shared widths and types for the ornek1 sliding-window adder.
package ornek1_pkg;

  localparam int DATA_W     = 8;
  localparam int SUM_W      = 10;
  localparam int MAX_WINDOW = 4;
  localparam int FILL_W     = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SUM_W-1:0]  sum_t;
  typedef logic [FILL_W-1:0] fill_t;

  function automatic sum_t zext_sample(input data_t d);
    return {{(SUM_W-DATA_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/ornek1_window_sum.sv
// Sample history, fill counter and next-sum adder for ornek1.
// Outputs are the values the window takes if the current sample is accepted.
import ornek1_pkg::*;

module ornek1_window_sum #(
  parameter int WINDOW = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  accept_i,
  input  data_t sample_i,
  output sum_t  sum_next_o,
  output logic  full_next_o
);

  // Only the WINDOW-1 most recent samples are kept; the incoming one completes the window.
  localparam int    HIST_N = MAX_WINDOW - 1;
  localparam fill_t WIN_C  = fill_t'(WINDOW);

  data_t hist_q [HIST_N] = '{default: 8'h00};
  data_t hist_d [HIST_N];
  fill_t fill_q = 3'd0;
  fill_t fill_d;
  sum_t  sum_next_s;

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    sum_next_s = zext_sample(sample_i);
    for (int i = 0; i < HIST_N; i++) begin
      if (i < WINDOW - 1) begin
        sum_next_s = sum_next_s + zext_sample(hist_q[i]);
      end else begin
        sum_next_s = sum_next_s;
      end
    end
    if (accept_i) begin
      hist_d[0] = (WINDOW > 1) ? sample_i : 8'h00;
      for (int i = 1; i < HIST_N; i++) begin
        hist_d[i] = (i < WINDOW - 1) ? hist_q[i-1] : 8'h00;
      end
      fill_d = (fill_q == WIN_C) ? fill_q : fill_q + 3'd1;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '{default: 8'h00};
      fill_q <= 3'd0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign sum_next_o  = sum_next_s;
  assign full_next_o = (fill_d == WIN_C);

endmodule

// File: rtl/ornek1.sv
// Streaming sliding-window adder: registered sum of the last WINDOW samples and a threshold flag.
// Define ORNEK1_STICKY_READY_EN to make ready_o latch high until reset.
import ornek1_pkg::*;

module ornek1 #(
  parameter int THRESHOLD = 60,
  parameter int WINDOW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] datain_i,
  output logic              ready_o,
  output logic [SUM_W-1:0]  dataout_o
);

  localparam sum_t THRESH_C = sum_t'(THRESHOLD);

  sum_t sum_next_s;
  logic full_next_s;
  logic hit_s;
  sum_t dataout_q = 10'd0;
  sum_t dataout_d;
  logic ready_q = 1'b0;
  logic ready_d;

  ornek1_window_sum #(
    .WINDOW(WINDOW)
  ) u_window_sum (
    .clk        (clk),
    .rst        (rst),
    .accept_i   (valid_i),
    .sample_i   (datain_i),
    .sum_next_o (sum_next_s),
    .full_next_o(full_next_s)
  );

  always_comb begin
    dataout_d = dataout_q;
    ready_d   = ready_q;
    hit_s     = full_next_s && (sum_next_s >= THRESH_C);
    if (valid_i) begin
      dataout_d = sum_next_s;
`ifdef ORNEK1_STICKY_READY_EN
      ready_d   = ready_q | hit_s;
`else
      ready_d   = hit_s;
`endif
    end else begin
      dataout_d = dataout_q;
      ready_d   = ready_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout_q <= 10'd0;
      ready_q   <= 1'b0;
    end else begin
      dataout_q <= dataout_d;
      ready_q   <= ready_d;
    end
  end

  assign dataout_o = dataout_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_ornek1.sv
// Directed bench for ornek1: queue-based window model plus hand-computed checkpoints.
module tb_ornek1;

  localparam int TH  = 60;
  localparam int WIN = 3;
`ifdef ORNEK1_STICKY_READY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] datain_i = 8'd0;
  logic       ready_o;
  logic [9:0] dataout_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  int q[$];
  int exp_sum = 0;
  bit exp_rdy = 1'b0;

  ornek1 #(.THRESHOLD(TH), .WINDOW(WIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .datain_i (datain_i),
    .ready_o  (ready_o),
    .dataout_o(dataout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_sum = 0;
    exp_rdy = 1'b0;
  endtask

  task automatic model_accept(input int d);
    bit hit;
    q.push_back(d);
    if (q.size() > WIN) void'(q.pop_front());
    exp_sum = 0;
    foreach (q[i]) exp_sum += q[i];
    hit = (q.size() == WIN) && (exp_sum >= TH);
    exp_rdy = STICKY ? (exp_rdy | hit) : hit;
  endtask

  // One clock of stimulus; optionally pin the outputs to literal values.
  task automatic step(input bit v, input int d, input bit lit, input int e_sum, input bit e_rdy);
    valid_i  = v;
    datain_i = d[7:0];
    @(posedge clk);
    #1;
    if (v) model_accept(d);
    if (lit) begin
      check("lit_sum", dataout_o, e_sum);
      check("lit_rdy", ready_o, e_rdy);
    end
  endtask

  // Pulse reset between edges and confirm the outputs clear immediately.
  task automatic async_reset();
    valid_i = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("rst_sum", dataout_o, 0);
    check("rst_rdy", ready_o, 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_sum", dataout_o, exp_sum);
      check("model_rdy", ready_o, exp_rdy);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum", dataout_o, 0);
    check("reset_rdy", ready_o, 0);
    rst = 1'b0;
    model_reset();
    started = 1'b1;

    // Fill
    step(1, 15, 1, 15, 0);
    step(1, 20, 1, 35, 0);
    step(1, 25, 1, 60, 1);
    // Steady state at the threshold boundary
    for (int k = 0; k < 12; k++) begin
      step(1, 15, 0, 0, 0);
      step(1, 20, 0, 0, 0);
      step(1, 25, 1, 60, 1);
    end
    // Drop below threshold
    step(1, 1, 1, 46, STICKY);
    step(1, 2, 1, 28, STICKY);
    step(1, 3, 1, 6, STICKY);
    step(1, 1, 1, 6, STICKY);
    // Hold with garbage on the data input
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 3, 1, 6, STICKY);
    for (int k = 0; k < 5; k++) step(0, 200, 1, 6, STICKY);
    step(1, 9, 1, 14, STICKY);

    // Async reset mid-operation
    async_reset();
    step(1, 30, 1, 30, 0);
    step(1, 30, 1, 60, 0);
    step(1, 30, 1, 90, 1);

    // Reset and valid on the same edge: the sample is dropped
    valid_i  = 1'b1;
    datain_i = 8'd100;
    rst      = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstwin_sum", dataout_o, 0);
    check("rstwin_rdy", ready_o, 0);
    step(1, 19, 1, 19, 0);
    step(1, 20, 1, 39, 0);
    step(1, 20, 1, 59, 0);
    step(1, 21, 1, 61, 1);
    // Maximum samples
    step(1, 255, 1, 296, 1);
    step(1, 255, 1, 531, 1);
    step(1, 255, 1, 765, 1);
    step(0, 0, 1, 765, 1);

    @(negedge clk);
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ornek1.md
Name: ornek1

Overview:
- Streaming sliding-window adder for 8-bit samples.
- Keeps the last WINDOW accepted samples and outputs their registered sum.
- Flags when the window is full and the sum reaches a programmable threshold.
- Sits after a simple valid-qualified sample source; the flag drives downstream "result ready" logic.

Parameters:
THRESHOLD, 60, compare level for ready_o (unsigned; legal range 0..1020)
WINDOW, 3, number of most-recent accepted samples summed (legal 1..4, so the sum fits 10 bits)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  qualifies datain_i; a sample is accepted on any rising edge where valid_i=1
datain_i  input  8  unsigned sample
ready_o  output  1  window full AND current sum >= THRESHOLD
dataout_o  output  10  unsigned sum of the last WINDOW accepted samples (fewer while filling)

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately): clears sample history, fill counter, dataout_o and ready_o to 0. All registers also power-up initialised to these values, so the block is defined in simulation even if rst is never asserted.
- Accept, rising edge with valid_i=1 and rst=0:
  - Shift datain_i into the history; the oldest sample drops out.
  - Fill counter increments, saturating at WINDOW.
  - dataout_o <= sum(previous WINDOW-1 samples) + datain_i.
- Latency: one cycle. The sum including a sample is visible immediately after the edge that accepts it.
- Empty slots during fill count as 0:
  - after the 1st accepted sample, dataout_o = s1;
  - after the 2nd, s1+s2; and so on.
- ready_o is registered and updated on the same edge as dataout_o: ready_o = (fill count after update == WINDOW) && (new sum >= THRESHOLD).
- ready_o is therefore 0 for the first WINDOW-1 accepted samples regardless of value.
- valid_i=0: history, counter, dataout_o and ready_o all hold.
- No back-pressure: every valid sample is consumed; no input-side ready.
- Arithmetic: zero-extend 8-bit samples to 10 bits and add unsigned. No overflow is possible for legal WINDOW.
- Compare is unsigned, with THRESHOLD zero-extended to 10 bits. Equality counts as reached (>=).
- Reset mid-window: history cleared, fill restarts from 0; the next accepted sample behaves as the 1st.
- Reset asserted on the same edge as valid_i=1: reset wins and the sample is discarded.

Optional Feature:
Macro: ORNEK1_STICKY_READY_EN
- Defined: ready_o latches. Once it has been 1 it stays 1 until reset, independent of later sums.
- Undefined: ready_o recomputed every accept as above (default).

Decomposition:
- Package ornek1_pkg: DATA_W=8, SUM_W=10, MAX_WINDOW=4, and a typedef sum_t (10-bit unsigned).
- One natural sub-module, ornek1_window_sum: shift register + adder tree + fill counter producing the sum and a full flag.
- The top adds the threshold compare, output registers and the sticky option.

Test Plan:
- Fill with THRESHOLD=60: valid 15,20,25 on consecutive edges -> dataout_o 15,35,60; ready_o 0,0,1.
- Steady state: repeat 15,20,25 x12 -> dataout_o stays 60 every cycle and ready_o stays 1 (60>=60 boundary).
- Drop below threshold: after ...15,20,25, feed 1,2,3,1 -> dataout_o 46,28,6,6; ready_o 0,0,0,0.
- Hold: drive valid_i=0 for 5 cycles with datain_i=200 -> dataout_o/ready_o unchanged; next valid 9 after window 1,2,3 -> dataout_o=14.
- Async reset mid-operation: pulse rst between edges -> outputs 0 at once; then 30,30 -> ready_o 0,0; then 30 -> dataout_o=90, ready_o=1.
- Sticky macro defined: 15,20,25 then 1,2,3 -> ready_o stays 1 through dataout_o=6; clears only on rst.
